// File: rtl/mem_bus_if_if.sv
// External memory bus: a single valid/ready request channel with same-cycle read data.
interface mem_bus_if_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  mem_valid;
    logic                  mem_instr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_wstrb;
    logic                  mem_ready;
    logic [31:0]           mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_bus_if.sv
// Memory stage: turns a control-FSM request into one bus transaction with alignment check,
// store lane steering and load extension. Optional bus timeout enabled by MEM_TIMEOUT_EN.
module mem_bus_if #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_mem,
    input  logic [1:0]            W_R_mem,
    input  logic [1:0]            wordsize_mem,
    input  logic                  sign_mem,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [31:0]           wdata_in,
    output logic                  busy_mem,
    output logic                  done_mem,
    output logic                  aligned_mem,
    output logic [31:0]           inst_out,
    output logic [31:0]           rdata_out,
    mem_bus_if_if.master          bus
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
`endif

    state_t                r_state, w_state_nxt;
    logic                  r_en_d;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_aligned, w_aligned_nxt;
    logic [31:0]           r_inst, w_inst_nxt;
    logic [31:0]           r_rdata, w_rdata_nxt;
    logic                  r_valid, w_valid_nxt;
    logic                  r_instr, w_instr_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [31:0]           r_wdata, w_wdata_nxt;
    logic [3:0]            r_wstrb, w_wstrb_nxt;
    logic [1:0]            r_size, w_size_nxt;
    logic                  r_sign, w_sign_nxt;
    logic [1:0]            r_lo, w_lo_nxt;
    logic                  r_fetch, w_fetch_nxt;
    logic                  r_write, w_write_nxt;

    logic                  w_req;
    logic                  w_fetch;
    logic                  w_write;
    logic [1:0]            w_size_req;
    logic                  w_misal;
    logic [3:0]            w_wstrb_req;
    logic [31:0]           w_wdata_req;
    logic [7:0]            w_lane_b;
    logic [15:0]           w_lane_h;
    logic [31:0]           w_load;

    assign w_req      = en_mem & ~r_en_d;
    assign w_fetch    = (W_R_mem == 2'b11);
    assign w_write    = (W_R_mem == 2'b00);
    assign w_size_req = (w_fetch || wordsize_mem[1]) ? SZ_WORD : wordsize_mem;
    assign w_misal    = ((w_size_req == SZ_HALF) && addr_in[0]) ||
                        ((w_size_req == SZ_WORD) && (addr_in[1:0] != 2'b00));

    // Store lane steering from the live request
    always_comb begin
        w_wstrb_req = 4'h0;
        w_wdata_req = wdata_in;
        case (w_size_req)
            SZ_BYTE: begin
                w_wstrb_req = 4'b0001 << addr_in[1:0];
                w_wdata_req = {4{wdata_in[7:0]}};
            end
            SZ_HALF: begin
                w_wstrb_req = 4'b0011 << addr_in[1:0];
                w_wdata_req = {2{wdata_in[15:0]}};
            end
            default: w_wstrb_req = 4'hF;
        endcase
        if (!w_write) begin
            w_wstrb_req = 4'h0;
        end
    end

    // Load lane select and extension from the latched request
    always_comb begin
        w_lane_b = 8'(bus.mem_rdata >> {r_lo, 3'b000});
        w_lane_h = r_lo[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (r_size)
            SZ_BYTE: w_load = {{24{r_sign & w_lane_b[7]}}, w_lane_b};
            SZ_HALF: w_load = {{16{r_sign & w_lane_h[15]}}, w_lane_h};
            default: w_load = bus.mem_rdata;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_aligned_nxt = r_aligned;
        w_inst_nxt    = r_inst;
        w_rdata_nxt   = r_rdata;
        w_valid_nxt   = r_valid;
        w_instr_nxt   = r_instr;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_wstrb_nxt   = r_wstrb;
        w_size_nxt    = r_size;
        w_sign_nxt    = r_sign;
        w_lo_nxt      = r_lo;
        w_fetch_nxt   = r_fetch;
        w_write_nxt   = r_write;
`ifdef MEM_TIMEOUT_EN
        w_tmo_nxt     = r_tmo;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_size_nxt  = w_size_req;
                    w_sign_nxt  = sign_mem;
                    w_lo_nxt    = addr_in[1:0];
                    w_fetch_nxt = w_fetch;
                    w_write_nxt = w_write;
                    if (w_misal) begin
                        w_state_nxt   = S_ERR;
                        w_aligned_nxt = 1'b0;
                    end else begin
                        w_state_nxt = S_REQ;
                        w_busy_nxt  = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_instr_nxt = w_fetch;
                        w_addr_nxt  = {addr_in[ADDR_WIDTH-1:2], 2'b00};
                        w_wdata_nxt = w_wdata_req;
                        w_wstrb_nxt = w_wstrb_req;
`ifdef MEM_TIMEOUT_EN
                        w_tmo_nxt   = '0;
`endif
                    end
                end
            end
            S_REQ: begin
                if (bus.mem_ready) begin
                    w_state_nxt = S_DONE;
                    w_valid_nxt = 1'b0;
                    w_done_nxt  = 1'b1;
                    if (r_fetch) begin
                        w_inst_nxt = bus.mem_rdata;
                    end else if (!r_write) begin
                        w_rdata_nxt = w_load;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt   = S_ERR;
                    w_valid_nxt   = 1'b0;
                    w_busy_nxt    = 1'b0;
                    w_aligned_nxt = 1'b0;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
`endif
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            S_ERR: begin
                w_state_nxt = S_ERR;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_en_d    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aligned <= 1'b1;
            r_inst    <= '0;
            r_rdata   <= '0;
            r_valid   <= 1'b0;
            r_instr   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_size    <= SZ_BYTE;
            r_sign    <= 1'b0;
            r_lo      <= '0;
            r_fetch   <= 1'b0;
            r_write   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_tmo     <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_en_d    <= en_mem;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_aligned <= w_aligned_nxt;
            r_inst    <= w_inst_nxt;
            r_rdata   <= w_rdata_nxt;
            r_valid   <= w_valid_nxt;
            r_instr   <= w_instr_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_wstrb   <= w_wstrb_nxt;
            r_size    <= w_size_nxt;
            r_sign    <= w_sign_nxt;
            r_lo      <= w_lo_nxt;
            r_fetch   <= w_fetch_nxt;
            r_write   <= w_write_nxt;
`ifdef MEM_TIMEOUT_EN
            r_tmo     <= w_tmo_nxt;
`endif
        end
    end

    assign busy_mem      = r_busy;
    assign done_mem      = r_done;
    assign aligned_mem   = r_aligned;
    assign inst_out      = r_inst;
    assign rdata_out     = r_rdata;
    assign bus.mem_valid = r_valid;
    assign bus.mem_instr = r_instr;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_wstrb = r_wstrb;

endmodule

// File: tb/tb_mem_bus_if.sv
// Bench for mem_bus_if: fixed vector table, corner-case sequences and random transactions vs a byte-level model.
module tb_mem_bus_if;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        en_mem;
    logic [1:0]  W_R_mem;
    logic [1:0]  wordsize_mem;
    logic        sign_mem;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        busy_mem;
    logic        done_mem;
    logic        aligned_mem;
    logic [31:0] inst_out;
    logic [31:0] rdata_out;

    mem_bus_if_if #(.ADDR_WIDTH(32)) bus_i ();

    mem_bus_if #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .en_mem      (en_mem),
        .W_R_mem     (W_R_mem),
        .wordsize_mem(wordsize_mem),
        .sign_mem    (sign_mem),
        .addr_in     (addr_in),
        .wdata_in    (wdata_in),
        .busy_mem    (busy_mem),
        .done_mem    (done_mem),
        .aligned_mem (aligned_mem),
        .inst_out    (inst_out),
        .rdata_out   (rdata_out),
        .bus         (bus_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wr;
        logic [1:0]  ws;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;
        logic [31:0] rdata;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata;
        logic [31:0] e_res;
    } vec_t;

    vec_t        vt[12];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] hold_inst  = 32'h0;
    logic [31:0] hold_rdata = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: size in bytes, alignment, lanes and extension from plain arithmetic
    function automatic int nbytes(input logic [1:0] wr, input logic [1:0] ws);
        if (wr == 2'b11) return 4;
        if (ws == 2'b00) return 1;
        if (ws == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic m_aligned(input logic [1:0] wr, input logic [1:0] ws, input logic [31:0] addr);
        return (int'(addr[1:0]) % nbytes(wr, ws)) == 0;
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [1:0] wr, input logic [1:0] ws, input logic [31:0] addr);
        int n;
        int unsigned m;
        n = nbytes(wr, ws);
        if (wr != 2'b00) return 4'h0;
        m = ((32'd1 << n) - 32'd1) << addr[1:0];
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] ws, input logic [31:0] wdata);
        int n;
        logic [31:0] r;
        n = nbytes(2'b00, ws);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wdata[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] wr, input logic [1:0] ws, input logic sg,
                                           input logic [31:0] addr, input logic [31:0] rdata);
        int n;
        longint unsigned mask, v;
        n    = nbytes(wr, ws);
        mask = (64'd1 << (8 * n)) - 64'd1;
        v    = (64'(rdata) >> (8 * int'(addr[1:0]))) & mask;
        if (sg && ((v >> (8 * n - 1)) & 64'd1) == 64'd1) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        en_mem = 1'b0;
        reset  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        hold_inst  = 32'h0;
        hold_rdata = 32'h0;
    endtask

    task automatic drive_req(input logic [1:0] wr, input logic [1:0] ws, input logic sg,
                             input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk); #1;
        W_R_mem = wr; wordsize_mem = ws; sign_mem = sg; addr_in = addr; wdata_in = wdata;
        en_mem = 1'b1;
        @(posedge clk); #1;
        en_mem = 1'b0;
    endtask

    task automatic run_txn(input string name, input vec_t v);
        drive_req(v.wr, v.ws, v.sg, v.addr, v.wdata);
        check({name, ".valid"}, 32'(bus_i.mem_valid), 32'd1);
        check({name, ".addr"},  bus_i.mem_addr, v.addr & ~32'h3);
        check({name, ".instr"}, 32'(bus_i.mem_instr), 32'(v.wr == 2'b11));
        check({name, ".wstrb"}, 32'(bus_i.mem_wstrb), 32'(v.e_wstrb));
        check({name, ".busy"},  32'(busy_mem), 32'd1);
        if (v.wr == 2'b00) check({name, ".wdata"}, bus_i.mem_wdata, v.e_wdata);
        for (int d = 0; d < v.dly; d++) begin
            @(posedge clk); #1;
            check({name, ".hold_valid"}, 32'(bus_i.mem_valid), 32'd1);
            check({name, ".hold_done"},  32'(done_mem), 32'd0);
            check({name, ".hold_wstrb"}, 32'(bus_i.mem_wstrb), 32'(v.e_wstrb));
            if (v.wr == 2'b00) check({name, ".hold_wdata"}, bus_i.mem_wdata, v.e_wdata);
        end
        bus_i.mem_ready = 1'b1;
        bus_i.mem_rdata = v.rdata;
        @(posedge clk); #1;
        bus_i.mem_ready = 1'b0;
        bus_i.mem_rdata = $urandom;
        check({name, ".done"},      32'(done_mem), 32'd1);
        check({name, ".valid_off"}, 32'(bus_i.mem_valid), 32'd0);
        @(posedge clk); #1;
        check({name, ".done_off"}, 32'(done_mem), 32'd0);
        check({name, ".busy_off"}, 32'(busy_mem), 32'd0);
        if (v.wr == 2'b11) begin
            hold_inst = v.e_res;
        end else if (v.wr != 2'b00) begin
            hold_rdata = v.e_res;
        end
        check({name, ".inst"},  inst_out, hold_inst);
        check({name, ".rdata"}, rdata_out, hold_rdata);
    endtask

    task automatic run_misal(input string name, input logic [1:0] wr, input logic [1:0] ws,
                             input logic [31:0] addr);
        drive_req(wr, ws, 1'b0, addr, 32'h0);
        check({name, ".valid"},   32'(bus_i.mem_valid), 32'd0);
        check({name, ".aligned"}, 32'(aligned_mem), 32'd0);
        check({name, ".busy"},    32'(busy_mem), 32'd0);
        bus_i.mem_ready = 1'b1;
        drive_req(2'b11, 2'b10, 1'b0, 32'h100, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check({name, ".stuck_valid"},   32'(bus_i.mem_valid), 32'd0);
            check({name, ".stuck_done"},    32'(done_mem), 32'd0);
            check({name, ".stuck_aligned"}, 32'(aligned_mem), 32'd0);
            @(posedge clk); #1;
        end
        bus_i.mem_ready = 1'b0;
        do_reset();
        check({name, ".aligned_rst"}, 32'(aligned_mem), 32'd1);
    endtask

    initial begin
        vec_t v;
        int   cnt;
        reset = 1'b0; en_mem = 1'b0; W_R_mem = 2'b00; wordsize_mem = 2'b00; sign_mem = 1'b0;
        addr_in = 32'h0; wdata_in = 32'h0;
        bus_i.mem_ready = 1'b0; bus_i.mem_rdata = 32'h0;

        vt[0]  = '{2'b11, 2'b00, 1'b0, 32'h100, 32'h0,        0, 32'h00000013, 4'h0, 32'h0,        32'h00000013};
        vt[1]  = '{2'b01, 2'b00, 1'b1, 32'h203, 32'h0,        0, 32'h80FFFFFF, 4'h0, 32'h0,        32'hFFFFFF80};
        vt[2]  = '{2'b01, 2'b00, 1'b0, 32'h203, 32'h0,        1, 32'h80FFFFFF, 4'h0, 32'h0,        32'h00000080};
        vt[3]  = '{2'b00, 2'b01, 1'b0, 32'h302, 32'h1234ABCD, 3, 32'h0,        4'hC, 32'hABCDABCD, 32'h0};
        vt[4]  = '{2'b00, 2'b00, 1'b0, 32'h101, 32'h00000055, 0, 32'h0,        4'h2, 32'h55555555, 32'h0};
        vt[5]  = '{2'b01, 2'b01, 1'b1, 32'h402, 32'h0,        0, 32'h80017FFF, 4'h0, 32'h0,        32'hFFFF8001};
        vt[6]  = '{2'b01, 2'b01, 1'b0, 32'h400, 32'h0,        2, 32'h00008765, 4'h0, 32'h0,        32'h00008765};
        vt[7]  = '{2'b01, 2'b10, 1'b1, 32'h500, 32'h0,        1, 32'hDEADBEEF, 4'h0, 32'h0,        32'hDEADBEEF};
        vt[8]  = '{2'b00, 2'b10, 1'b0, 32'h604, 32'hCAFEF00D, 0, 32'h0,        4'hF, 32'hCAFEF00D, 32'h0};
        vt[9]  = '{2'b11, 2'b00, 1'b1, 32'h020, 32'h0,        0, 32'hFFFFFFFF, 4'h0, 32'h0,        32'hFFFFFFFF};
        vt[10] = '{2'b10, 2'b11, 1'b1, 32'h008, 32'h0,        0, 32'h12345678, 4'h0, 32'h0,        32'h12345678};
        vt[11] = '{2'b01, 2'b00, 1'b1, 32'h201, 32'h0,        0, 32'h00007F00, 4'h0, 32'h0,        32'h0000007F};

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst.busy",    32'(busy_mem), 32'd0);
        check("rst.done",    32'(done_mem), 32'd0);
        check("rst.aligned", 32'(aligned_mem), 32'd1);
        check("rst.valid",   32'(bus_i.mem_valid), 32'd0);
        check("rst.instr",   32'(bus_i.mem_instr), 32'd0);
        check("rst.wstrb",   32'(bus_i.mem_wstrb), 32'd0);
        check("rst.addr",    bus_i.mem_addr, 32'h0);
        check("rst.wdata",   bus_i.mem_wdata, 32'h0);
        check("rst.inst",    inst_out, 32'h0);
        check("rst.rdata",   rdata_out, 32'h0);

        for (int i = 0; i < 12; i++) run_txn($sformatf("vec%0d", i), vt[i]);

        run_misal("misal_word", 2'b01, 2'b10, 32'h401);
        run_misal("misal_half", 2'b00, 2'b01, 32'h011);
        run_misal("misal_fetch", 2'b11, 2'b00, 32'h102);

        // Reset in the middle of a pending bus request
        drive_req(2'b11, 2'b10, 1'b0, 32'h700, 32'h0);
        check("midrst.valid_pre", 32'(bus_i.mem_valid), 32'd1);
        #3 reset = 1'b0;
        #1;
        check("midrst.valid", 32'(bus_i.mem_valid), 32'd0);
        check("midrst.busy",  32'(busy_mem), 32'd0);
        hold_inst = 32'h0; hold_rdata = 32'h0;
        @(posedge clk); #1 reset = 1'b1;
        bus_i.mem_ready = 1'b1;
        @(posedge clk); #1;
        check("midrst.no_done", 32'(done_mem), 32'd0);
        bus_i.mem_ready = 1'b0;
        v = '{2'b11, 2'b00, 1'b0, 32'h100, 32'h0, 0, 32'h00000013, 4'h0, 32'h0, 32'h00000013};
        run_txn("midrst.fetch", v);

`ifdef MEM_TIMEOUT_EN
        drive_req(2'b11, 2'b10, 1'b0, 32'h040, 32'h0);
        cnt = 0;
        while (bus_i.mem_valid === 1'b1 && cnt < 20) begin
            cnt++;
            @(posedge clk); #1;
        end
        check("tmo.cycles",  32'(cnt), 32'(TMO));
        check("tmo.aligned", 32'(aligned_mem), 32'd0);
        check("tmo.done",    32'(done_mem), 32'd0);
        check("tmo.busy",    32'(busy_mem), 32'd0);
        do_reset();
`else
        cnt = 0;
`endif

        for (int i = 0; i < 60; i++) begin
            v.wr    = 2'($urandom_range(0, 3));
            v.ws    = 2'($urandom_range(0, 3));
            v.sg    = 1'($urandom_range(0, 1));
            v.addr  = $urandom & 32'h0000_FFFF;
            v.wdata = $urandom;
            v.dly   = $urandom_range(0, 3);
            v.rdata = $urandom;
            if (m_aligned(v.wr, v.ws, v.addr)) begin
                v.e_wstrb = m_wstrb(v.wr, v.ws, v.addr);
                v.e_wdata = m_wdata(v.ws, v.wdata);
                v.e_res   = m_load(v.wr, v.ws, v.sg, v.addr, v.rdata);
                run_txn($sformatf("rnd%0d", i), v);
            end else begin
                run_misal($sformatf("rnd%0d", i), v.wr, v.ws, v.addr);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_if.md
Name: mem_bus_if

Overview:
- Memory interface stage directly downstream of the core control FSM.
- Converts the FSM's en_mem / W_R_mem / wordsize_mem / sign_mem request into a single valid/ready transaction on the external memory bus.
- Performs the alignment check, write byte-lane steering and read sign/zero extension.
- Returns done_mem, busy_mem and aligned_mem to the FSM, the fetched instruction to decode, and load data to writeback.

Parameters:
- ADDR_WIDTH, 32, width of addr_in and mem_addr.
- TIMEOUT_CYCLES, 255, maximum cycles mem_valid may wait for mem_ready. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- en_mem  in  1  request level from FSM; a request is its rising edge (en_mem=1 while previous-cycle en_mem=0)
- W_R_mem  in  2  2'b11 instruction fetch, 2'b01 data read (load), 2'b00 data write (store); 2'b10 reserved, treated as read
- wordsize_mem  in  2  00 byte, 01 half, 10 word, 11 treated as word; ignored for fetch (always word)
- sign_mem  in  1  1 = sign-extend load data, 0 = zero-extend
- addr_in  in  ADDR_WIDTH  byte address (PC for fetch, effective address for data)
- wdata_in  in  32  store data, right-justified
- busy_mem  out  1  high from request capture until done_mem
- done_mem  out  1  one-cycle completion pulse
- aligned_mem  out  1  low means misaligned request captured
- inst_out  out  32  last fetched instruction word
- rdata_out  out  32  last load result, extended
- mem_valid  out  1  bus request
- mem_instr  out  1  bus request is an instruction fetch
- mem_addr  out  ADDR_WIDTH  word address {addr[ADDR_WIDTH-1:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte write enables; 0 for reads
- mem_ready  in  1  bus completion; mem_rdata valid same cycle
- mem_rdata  in  32  bus read data

Behaviour:
- Reset values:
  - busy_mem=0, done_mem=0, aligned_mem=1, mem_valid=0, mem_instr=0, mem_wstrb=0.
  - mem_addr, mem_wdata, inst_out, rdata_out = 0.
  - State = IDLE; internal en_mem delay flop = 0.
- State machine (IDLE, REQ, DONE, ERR):
  - IDLE:
    - Request edge seen: latch kind, size, sign, addr[1:0]; busy_mem=1.
    - If aligned: drive mem_valid=1 with mem_addr/mem_wdata/mem_wstrb/mem_instr next cycle; go to REQ.
    - If misaligned: go to ERR.
  - REQ:
    - mem_valid held with all bus outputs stable until mem_ready=1.
    - On mem_ready: mem_valid=0; capture data; go to DONE.
  - DONE:
    - done_mem=1 for exactly this cycle; busy_mem=0 next cycle; return to IDLE.
  - ERR:
    - aligned_mem=0, sticky until reset.
    - No bus transaction; busy_mem=0; done_mem never pulses.
- Alignment rules:
  - Half: misaligned if addr[0]=1.
  - Word and fetch: misaligned if addr[1:0]!=0.
  - Byte: always aligned.
- Latency: request edge sampled at cycle N → mem_valid high at N+1 → mem_ready sampled at cycle M → done_mem high at M+1. Zero-wait bus gives done_mem at N+2.
- Write steering:
  - byte: mem_wstrb=4'b0001<<addr[1:0], mem_wdata={4{wdata_in[7:0]}}
  - half: mem_wstrb=4'b0011<<addr[1:0], mem_wdata={2{wdata_in[15:0]}}
  - word: mem_wstrb=4'hF, mem_wdata=wdata_in
- Read extraction:
  - Select byte/half lane by latched addr[1:0], then extend per sign_mem to 32 bits into rdata_out.
  - Fetch writes the full mem_rdata to inst_out; rdata_out is unchanged.
- Output holding: inst_out and rdata_out hold until overwritten by the next completed transaction of their kind.
- Request edge while busy_mem=1 or in ERR: ignored. mem_ready while mem_valid=0: ignored.
- Reset mid-transaction: immediate abort; mem_valid drops asynchronously; no done_mem.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- When defined:
  - An 8+ bit counter runs while in REQ.
  - If TIMEOUT_CYCLES elapse without mem_ready: mem_valid=0, go to ERR, aligned_mem=0, so the FSM traps.
  - Counter clears on each entry to REQ.
- When undefined: no counter; REQ waits indefinitely.

Test Plan:
- Fetch, addr_in=0x100, mem_ready 0-wait, mem_rdata=0x00000013 → mem_addr=0x100, mem_instr=1, mem_wstrb=0; done_mem pulses at N+2; inst_out=0x13.
- Load byte signed, addr 0x203, mem_rdata=0x80FFFFFF → rdata_out=0xFFFFFF80. Same with sign_mem=0 → 0x00000080.
- Store half, addr 0x302, wdata_in=0x1234ABCD, 3-cycle mem_ready delay → mem_wstrb=4'b1100, mem_wdata=0xABCDABCD held stable 3 cycles; done_mem one cycle after mem_ready.
- Load word, addr 0x401 → no mem_valid, aligned_mem=0 next cycle and stays 0; no done_mem; reset restores aligned_mem=1.
- Reset asserted while in REQ → mem_valid=0 immediately, busy_mem=0; next fetch proceeds normally.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready never asserted → mem_valid drops after 4 cycles in REQ; aligned_mem=0.
